// File: rtl/dds_voice_scheduler.sv
// rtl/dds_voice_scheduler.sv - polyphonic voice allocator with a shared round-robin phase accumulator
// Optional feature macro: DDS_SUSTAIN_EN (adds sustain_i and per-slot held bits)
module dds_voice_scheduler #(
  parameter  int NUM_VOICES = 8,
  parameter  int PHASE_W    = 32,
  parameter  int NOTE_W     = 8,
  localparam int SW         = $clog2(NUM_VOICES),
  localparam int CW         = SW + 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               ev_valid_i,
  output logic               ev_ready_o,
  input  logic               ev_on_i,
  input  logic [NOTE_W-1:0]  ev_note_i,
  input  logic [PHASE_W-1:0] ev_inc_i,
`ifdef DDS_SUSTAIN_EN
  input  logic               sustain_i,
`endif
  output logic [SW-1:0]      slot_o,
  output logic [PHASE_W-1:0] phase_o,
  output logic               gate_o,
  output logic [NOTE_W-1:0]  note_out_o,
  output logic [CW-1:0]      active_cnt_o
);

  typedef enum logic {S_IDLE, S_ALLOC} state_t;

  state_t              state_q, state_d;
  logic                init_q, init_d;
  logic                accept, alloc_en;

  logic                lat_on_q, lat_on_d;
  logic [NOTE_W-1:0]   lat_note_q, lat_note_d;
  logic [PHASE_W-1:0]  lat_inc_q, lat_inc_d;

  logic [PHASE_W-1:0]  phase_q [NUM_VOICES];
  logic [PHASE_W-1:0]  phase_d [NUM_VOICES];
  logic [PHASE_W-1:0]  inc_q   [NUM_VOICES];
  logic [PHASE_W-1:0]  inc_d   [NUM_VOICES];
  logic [NOTE_W-1:0]   note_q  [NUM_VOICES];
  logic [NOTE_W-1:0]   note_d  [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q, gate_d;
  logic [NUM_VOICES-1:0] held_q, held_d;

  logic [SW-1:0]       r_q, r_d;
  logic [SW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       cnt_d;

  logic [SW-1:0]       slot_q;
  logic [PHASE_W-1:0]  pres_phase_q, pres_phase_d;
  logic                pres_gate_q;
  logic [NOTE_W-1:0]   pres_note_q;
  logic [CW-1:0]       cnt_q;

  logic                hit_found, free_found, steal;
  logic [SW-1:0]       hit_idx, free_idx, tgt;
  logic [PHASE_W-1:0]  sum;

  assign accept = ev_valid_i & ev_ready_o;
  assign sum    = phase_q[r_q] + inc_q[r_q];
  assign init_d = 1'b1;
  assign r_d    = r_q + SW'(1);

  // Event FSM state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
    end
  end

  // Event FSM next state: accept in IDLE, spend exactly one cycle in ALLOC
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ALLOC;
      S_ALLOC: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Event FSM outputs: ready only once the first clock after reset has passed
  always_comb begin
    ev_ready_o = 1'b0;
    alloc_en   = 1'b0;
    case (state_q)
      S_IDLE:  ev_ready_o = init_q;
      S_ALLOC: alloc_en   = 1'b1;
      default: ev_ready_o = 1'b0;
    endcase
  end

  // Slot search: lowest gated slot with the latched note, lowest ungated slot
  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (gate_q[i] && (note_q[i] == lat_note_q)) begin
        hit_found = 1'b1;
        hit_idx   = SW'(i);
      end
      if (!gate_q[i]) begin
        free_found = 1'b1;
        free_idx   = SW'(i);
      end
    end
    steal = lat_on_q & ~hit_found & ~free_found;
    if (hit_found)       tgt = hit_idx;
    else if (free_found) tgt = free_idx;
    else                 tgt = ptr_q;
  end

  // Next slot table: accumulator step first, then the ALLOC write overrides it
  always_comb begin
    phase_d    = phase_q;
    inc_d      = inc_q;
    note_d     = note_q;
    gate_d     = gate_q;
    held_d     = held_q;
    ptr_d      = ptr_q;
    lat_on_d   = lat_on_q;
    lat_note_d = lat_note_q;
    lat_inc_d  = lat_inc_q;
    if (accept) begin
      lat_on_d   = ev_on_i;
      lat_note_d = ev_note_i;
      lat_inc_d  = ev_inc_i;
    end
    if (gate_q[r_q]) phase_d[r_q] = sum;
`ifdef DDS_SUSTAIN_EN
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (held_q[i] && !sustain_i) begin
        gate_d[i] = 1'b0;
        held_d[i] = 1'b0;
      end
    end
`endif
    if (alloc_en) begin
      if (lat_on_q) begin
        phase_d[tgt] = '0;
        inc_d[tgt]   = lat_inc_q;
        note_d[tgt]  = lat_note_q;
        gate_d[tgt]  = 1'b1;
        held_d[tgt]  = 1'b0;
        if (steal) ptr_d = ptr_q + SW'(1);
      end else if (hit_found) begin
`ifdef DDS_SUSTAIN_EN
        if (sustain_i) begin
          held_d[tgt] = 1'b1;
          gate_d[tgt] = 1'b1;
        end else begin
          held_d[tgt] = 1'b0;
          gate_d[tgt] = 1'b0;
        end
`else
        gate_d[tgt] = 1'b0;
`endif
      end
    end
  end

  // Popcount of gates and the presented phase for the slot being visited
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NUM_VOICES; i++) cnt_d = cnt_d + CW'(gate_q[i]);
    pres_phase_d = gate_q[r_q] ? sum : phase_q[r_q];
  end

  // Slot table, pointers and latched event registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase_q[i] <= '0;
        inc_q[i]   <= '0;
        note_q[i]  <= '0;
      end
      gate_q     <= '0;
      held_q     <= '0;
      ptr_q      <= '0;
      r_q        <= '0;
      lat_on_q   <= 1'b0;
      lat_note_q <= '0;
      lat_inc_q  <= '0;
    end else begin
      phase_q    <= phase_d;
      inc_q      <= inc_d;
      note_q     <= note_d;
      gate_q     <= gate_d;
      held_q     <= held_d;
      ptr_q      <= ptr_d;
      r_q        <= r_d;
      lat_on_q   <= lat_on_d;
      lat_note_q <= lat_note_d;
      lat_inc_q  <= lat_inc_d;
    end
  end

  // Registered presentation of the visited slot and the active count
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      slot_q       <= '0;
      pres_phase_q <= '0;
      pres_gate_q  <= 1'b0;
      pres_note_q  <= '0;
      cnt_q        <= '0;
    end else begin
      slot_q       <= r_q;
      pres_phase_q <= pres_phase_d;
      pres_gate_q  <= gate_q[r_q];
      pres_note_q  <= note_q[r_q];
      cnt_q        <= cnt_d;
    end
  end

  assign slot_o       = slot_q;
  assign phase_o      = pres_phase_q;
  assign gate_o       = pres_gate_q;
  assign note_out_o   = pres_note_q;
  assign active_cnt_o = cnt_q;

endmodule
